// File: rtl/lcm_fsm.sv
// rtl/lcm_fsm.sv - sequential LCM engine: subtractive GCD, restoring divide, shift-add multiply
// Optional feature macro: LCM_GCD_OUT_EN adds the gcd_out port.
module lcm_fsm #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] op,
   output logic               err
`ifdef LCM_GCD_OUT_EN
   ,
   output logic [WIDTH-1:0]   gcd_out
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GCD  = 3'd1,
      DIV  = 3'd2,
      MUL  = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;

   // r_a/r_b are the GCD working pair; once equal, r_a holds g and is the divisor.
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acap;
   logic [WIDTH-1:0]   r_bcap;
   // r_q: dividend shifting out / quotient shifting in, then multiplier shifting right.
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_rem;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_op;
   logic               r_err;
`ifdef LCM_GCD_OUT_EN
   logic [WIDTH-1:0]   r_gcd;
`endif

   logic               w_zero_in;
   logic               w_cnt_last;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;
   logic               w_fits;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_zero_in  = (A == '0) || (B == '0);
   assign w_cnt_last = (r_cnt == CNT_LAST);

   // Restoring divide step: a borrow out of the top bit means the divisor did not fit.
   assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_a};
   assign w_fits   = ~w_diff[WIDTH];

   // Shift-add multiply step; the 2*WIDTH accumulator cannot overflow.
   assign w_acc_next = r_q[0] ? (r_acc + r_mcand) : r_acc;

   // State register; reset wins over any start in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and status outputs.
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = w_zero_in ? FIN : GCD;
            end
         end
         GCD: begin
            busy = 1'b1;
            if (r_a == r_b) begin
               w_next = DIV;
            end
         end
         DIV: begin
            busy = 1'b1;
            if (w_cnt_last) begin
               w_next = MUL;
            end
         end
         MUL: begin
            busy = 1'b1;
            if (w_cnt_last) begin
               w_next = FIN;
            end
         end
         FIN: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, GCD, divide, multiply and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_acap  <= '0;
         r_bcap  <= '0;
         r_q     <= '0;
         r_rem   <= '0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
         r_op    <= '0;
         r_err   <= 1'b0;
`ifdef LCM_GCD_OUT_EN
         r_gcd   <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt <= '0;
                  if (w_zero_in) begin
                     r_op  <= '0;
                     r_err <= 1'b1;
`ifdef LCM_GCD_OUT_EN
                     r_gcd <= '0;
`endif
                  end else begin
                     r_a    <= A;
                     r_b    <= B;
                     r_acap <= A;
                     r_bcap <= B;
                  end
               end
            end
            GCD: begin
               if (r_a > r_b) begin
                  r_a <= r_a - r_b;
               end else if (r_b > r_a) begin
                  r_b <= r_b - r_a;
               end else begin
                  r_q   <= r_acap;
                  r_rem <= '0;
                  r_cnt <= '0;
               end
            end
            DIV: begin
               r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
               r_q   <= {r_q[WIDTH-2:0], w_fits};
               if (w_cnt_last) begin
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  r_mcand <= {{WIDTH{1'b0}}, r_bcap};
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            MUL: begin
               r_acc   <= w_acc_next;
               r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
               r_q     <= {1'b0, r_q[WIDTH-1:1]};
               if (w_cnt_last) begin
                  r_cnt <= '0;
                  r_op  <= w_acc_next;
                  r_err <= 1'b0;
`ifdef LCM_GCD_OUT_EN
                  r_gcd <= r_a;
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign op  = r_op;
   assign err = r_err;
`ifdef LCM_GCD_OUT_EN
   assign gcd_out = r_gcd;
`endif

endmodule

// File: tb/tb_lcm_fsm.sv
// tb/tb_lcm_fsm.sv - scoreboard bench for lcm_fsm
module tb_lcm_fsm;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           busy;
   logic           done;
   logic [2*W-1:0] op;
   logic           err;
`ifdef LCM_GCD_OUT_EN
   logic [W-1:0]   gcd_out;
`endif

   always #5 clk = ~clk;

   lcm_fsm #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .start (start),
      .busy  (busy),
      .done  (done),
      .op    (op),
      .err   (err)
`ifdef LCM_GCD_OUT_EN
      ,
      .gcd_out (gcd_out)
`endif
   );

   typedef struct {
      logic [63:0] op;
      logic        err;
      int          lat;
      logic [31:0] g;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_bad = 0;
   logic [63:0] last_op = 64'd0;
   logic        last_err = 1'b0;
   logic [63:0] got_op;
   int          got_lat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint unsigned x, y, t, sa, sbv;
      int n;
      if (a == 0 || b == 0) begin
         e.op = 64'd0; e.err = 1'b1; e.lat = 1; e.g = 32'd0;
         return e;
      end
      x = a; y = b;
      while (y != 0) begin
         t = x % y; x = y; y = t;
      end
      sa = a; sbv = b; n = 1;
      while (sa != sbv) begin
         if (sa > sbv) sa = sa - sbv;
         else sbv = sbv - sa;
         n++;
      end
      e.g   = x[31:0];
      e.op  = (longint'(a) / x) * longint'(b);
      e.err = 1'b0;
      e.lat = n + 2 * W + 1;
      return e;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int repulse,
                         output logic [63:0] r_op, output int r_lat);
      exp_t e;
      int   cnt;
      logic seen;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      sb.push_back(model(a, b));
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom;
      cnt = 1;
      seen = done;
      if (a != 0 && b != 0) begin
         check("busy_after_start", busy, 1);
         check("op_held_while_busy", op, last_op);
         check("err_held_while_busy", err, last_err);
      end
      while (!seen && cnt < 5000) begin
         if (repulse != 0 && cnt == repulse) begin
            start = 1'b1; A = 32'd1; B = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cnt++;
         seen = done;
      end
      start = 1'b0;
      if (!seen) check("done_timeout", 0, 1);
      e = sb.pop_front();
      check("latency", cnt, e.lat);
      check("op", op, e.op);
      check("err", err, e.err);
      check("busy_at_done", busy, 0);
`ifdef LCM_GCD_OUT_EN
      check("gcd_out", gcd_out, e.g);
`endif
      r_op = op; r_lat = cnt;
      last_op = e.op; last_err = e.err;
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("op_held_after", op, e.op);
   endtask

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_op", op, 0);
      check("rst_err", err, 0);
      // start coinciding with reset must be ignored
      A = 32'd5; B = 32'd5; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("start_in_rst_busy", busy, 0);
      check("start_in_rst_done", done, 0);

      run_op(32'd15, 32'd6, 0, got_op, got_lat);
      check("v15_6_lat", got_lat, 69);
      check("v15_6_op", got_op, 64'd30);
      run_op(32'd6, 32'd20, 0, got_op, got_lat);
      check("v6_20_op", got_op, 64'd60);
      run_op(32'd10, 32'd10, 0, got_op, got_lat);
      check("v10_10_lat", got_lat, 66);
      check("v10_10_op", got_op, 64'd10);
      run_op(32'd94665, 32'd544257, 0, got_op, got_lat);
      check("vbig_op", got_op, 64'd17174029635);
      run_op(32'd15625, 32'd3125, 0, got_op, got_lat);
      check("v15625_op", got_op, 64'd15625);
      run_op(32'd0, 32'd7, 0, got_op, got_lat);
      check("vzero_lat", got_lat, 1);
      check("vzero_err", err, 1);
      run_op(32'd6, 32'd20, 0, got_op, got_lat);
      check("err_cleared", err, 0);

      // restart attempt while busy is ignored
      run_op(32'd15, 32'd6, 10, got_op, got_lat);
      check("repulse_op", got_op, 64'd30);
      check("repulse_lat", got_lat, 69);
      repeat (80) @(negedge clk);
      check("repulse_no_extra_busy", busy, 0);

      // start held high: FIN ignores it, next IDLE accepts it
      A = 32'd0; B = 32'd7; start = 1'b1;
      @(negedge clk); check("hold_done1", done, 1);
      @(negedge clk); check("hold_gap", done, 0);
      @(negedge clk); check("hold_done2", done, 1);
      start = 1'b0;
      @(negedge clk); check("hold_after", done, 0);
      last_op = 64'd0; last_err = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(32'($urandom_range(1, 400)), 32'($urandom_range(1, 400)), 0, got_op, got_lat);
      end
      run_op(32'd65535, 32'd65535, 0, got_op, got_lat);
      check("vfull_op", got_op, 64'd65535);

      // reset in the middle of MUL aborts with no done
      @(negedge clk);
      A = 32'd15; B = 32'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 1; i < 50; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_op", op, 0);
      check("abort_err", err, 0);
      check("abort_done", done, 0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      last_op = 64'd0; last_err = 1'b0;

      run_op(32'd6, 32'd20, 0, got_op, got_lat);
      check("recover_op", got_op, 64'd60);
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/lcm_fsm.md
LCM_FSM -- requirements
Module: lcm_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port A  input  WIDTH  first operand, unsigned, sampled only on an accepted start.
REQ-005 SHALL have port B  input  WIDTH  second operand, unsigned, sampled only on an accepted start.
REQ-006 SHALL have port start  input  1  request a computation.
REQ-007 SHALL have port busy  output  1  high from the cycle after an accepted start until done is high.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking op valid.
REQ-009 SHALL have port op  output  2*WIDTH  least common multiple of A and B, held until the next accepted start.
REQ-010 SHALL have port err  output  1  high with done when either operand is zero, held with op.

Function
REQ-011 SHALL implement states IDLE, GCD, DIV, MUL, FIN.
REQ-012 SHALL accept start only in IDLE (busy=0); start while busy SHALL be ignored with no effect.
REQ-013 On an accepted start with A!=0 and B!=0: SHALL capture A, B and enter GCD next cycle.
REQ-014 On an accepted start with A==0 or B==0: SHALL enter FIN directly; op=0, err=1.
REQ-015 GCD: per cycle, if a>b then a<=a-b; if b>a then b<=b-a; if a==b then g=a and go to DIV; each subtraction and the final equality cycle cost one cycle each (N cycles total).
REQ-016 DIV: restoring shift-subtract; SHALL compute q = A_captured / g in exactly WIDTH cycles; remainder is always zero.
REQ-017 MUL: shift-add; SHALL compute q * B_captured into a 2*WIDTH accumulator in exactly WIDTH cycles with no truncation.
REQ-018 FIN: SHALL assert done for exactly one cycle, update op/err, and return to IDLE next cycle.
REQ-019 Latency SHALL be exactly N + 2*WIDTH + 1 cycles from the start-sampling edge to done high; 1 cycle for zero operands.
REQ-020 busy SHALL be high in GCD, DIV, MUL and low in IDLE and FIN.
REQ-021 start high in FIN SHALL be ignored; start held continuously SHALL be accepted again in the first IDLE cycle.
REQ-022 A==B SHALL yield op=A with N=1.
REQ-023 err SHALL clear to 0 on the next accepted start with nonzero operands, at the time op updates.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, op=0, err=0, and clear all internal registers.
REQ-025 rst asserted mid-operation SHALL abort the computation without asserting done; start in the same cycle as rst SHALL be ignored.

Configuration
REQ-026 With macro LCM_GCD_OUT_EN defined, SHALL add output port gcd_out (WIDTH bits), updated with op in FIN (0 on err), reset to 0.
REQ-027 Without LCM_GCD_OUT_EN, port gcd_out SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-028 A=15, B=6, start pulse -> done exactly 69 cycles later (N=4, WIDTH=32), op=30, err=0; gcd_out=3 if enabled.
REQ-029 A=6, B=20 -> op=60; A=10, B=10 -> op=10 with done 66 cycles after start.
REQ-030 A=94665, B=544257 -> op=17174029635 (exceeds 32 bits), err=0; gcd_out=3 if enabled.
REQ-031 A=15625, B=3125 -> op=15625; then A=0, B=7 -> done 1 cycle after start, op=0, err=1.
REQ-032 start re-pulsed with A=1, B=1 during busy -> ignored, first result unchanged; rst raised mid-MUL -> busy=0, op=0 next cycle, no done.
